pc_gen: RTL

Parametrised program-counter generator for the RV64 fetch stage, successor to the fixed 32-bit PC register. Holds the fetch PC, advances it on an accepted fetch handshake, and redirects it on trap or jump with fixed priority. A jump that arrives during a stall is buffered rather than lost, and misaligned jump targets are rejected. Sits between the execute/CSR redirect sources and the instruction-memory request port.

---
 rtl/pc_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter for RV64: sequential advance on an accepted fetch,
// trap/jump redirects with fixed priority, and a one-deep buffer for jumps seen while stalled.
//
// Handshake: a fetch at pc_o is presented while fetch_valid_o=1 and is taken on an edge
// where fetch_valid_o & fetch_ready_i & ~stall_i; pc_o advances only on such an edge.
module pc_gen #(
  parameter int unsigned XLEN      = 64,
  parameter logic [63:0] RESET_VEC = 64'h0000_0000_8000_0000,
  parameter int unsigned STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            redirect_o,
  output logic            pc_misalign_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] RESET_PC = RESET_VEC[XLEN-1:0];
  localparam logic [XLEN-1:0] STEP_INC = XLEN'(STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            jump_aligned;
  logic            jump_misaligned;
  logic [XLEN-1:0] trap_pc;

  assign accept          = fetch_valid_q & fetch_ready_i & ~stall_i;
  assign jump_aligned    = jump_en_i & (jump_addr_i[1:0] == 2'b00);
  assign jump_misaligned = jump_en_i & (jump_addr_i[1:0] != 2'b00);
  assign trap_pc         = {trap_addr_i[XLEN-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    redirect_d    = 1'b0;
    misalign_d    = 1'b0;
    // Fetch becomes valid on the edge that leaves BOOT and stays valid until reset.
    fetch_valid_d = 1'b1;

    if (trap_en_i) begin
      pc_d       = trap_pc;
      redirect_d = 1'b1;
      pend_d     = '0;
      state_d    = RUN;
    end else if (jump_misaligned) begin
      // Rejected target: pending jump survives, only a plain RUN advance may happen.
      misalign_d = 1'b1;
      if (state_q == RUN && accept) pc_d = pc_q + STEP_INC;
      if (state_q == BOOT) state_d = RUN;
    end else if (jump_aligned && (stall_i || state_q == BOOT)) begin
      pend_d  = jump_addr_i;
      state_d = HOLD;
    end else if (jump_aligned) begin
      pc_d       = jump_addr_i;
      redirect_d = 1'b1;
      state_d    = RUN;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        HOLD: begin
          if (!stall_i) begin
            pc_d       = pend_q;
            redirect_d = 1'b1;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (accept) pc_d = pc_q + STEP_INC;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pend_q        <= '0;
      fetch_valid_q <= 1'b0;
      redirect_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      fetch_valid_q <= fetch_valid_d;
      redirect_q    <= redirect_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign redirect_o    = redirect_q;
  assign pc_misalign_o = misalign_q;
  assign state_o       = state_q;

endmodule
